// File: rtl/game_mmio_ctrl.sv
// game_mmio_ctrl: fabric-side controller behind the HPS Avalon-MM conduit.
// Decodes HPS register accesses. Turns button presses into timestamped entries
// in an event FIFO. Runs the game tick prescaler. Arbitrates a 16-word shared
// bank between the HPS, which always wins, and the fabric game engine.
// Optional build macro: GAME_BTN_DEBOUNCE_EN adds per-button debounce counters.
module game_mmio_ctrl #(
  parameter int unsigned BTN_W      = 5,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DEB_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       avs_address,
  input  logic [3:0]       avs_byteenable,
  input  logic [31:0]      avs_writedata,
  input  logic             avs_write,
  input  logic             avs_read,
  output logic [31:0]      avs_readdata,
  input  logic [BTN_W-1:0] btn_in,
  input  logic             eng_req,
  input  logic             eng_we,
  input  logic [3:0]       eng_addr,
  input  logic [31:0]      eng_wdata,
  output logic             eng_gnt,
  output logic [31:0]      eng_rdata,
  output logic             eng_rvalid,
  output logic             tick
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [4:0] {
    REG_CTRL     = 5'h00,
    REG_STATUS   = 5'h01,
    REG_EVENT    = 5'h02,
    REG_TICK_DIV = 5'h03,
    REG_TICK_CNT = 5'h04
  } reg_addr_e;

  logic             run;
  logic [23:0]      tick_div;
  logic [23:0]      presc;
  logic [31:0]      tick_cnt;
  logic [31:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic [31:0]      bank [16];

  logic [BTN_W-1:0] sync1, sync2, sync_lvl, level, level_q, press;

  logic hps_bank, wr_ctrl, wr_status, wr_div, rd_event, wr_bank;
  logic flush, ovf_clr, empty, full, pop_req, push_req, do_pop, do_push, ovf_set;
  logic [31:0] div_merged, bank_merged, status_word, rd_mux;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_val;
    for (int unsigned i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = new_val[8*i +: 8];
    return r;
  endfunction

  // Address decode, FIFO control and arbitration.
  always_comb begin
    hps_bank  = (avs_read | avs_write) & avs_address[4];
    wr_bank   = avs_write & avs_address[4];
    wr_ctrl   = avs_write & (avs_address == REG_CTRL);
    wr_status = avs_write & (avs_address == REG_STATUS);
    wr_div    = avs_write & (avs_address == REG_TICK_DIV);
    rd_event  = avs_read  & (avs_address == REG_EVENT);
    flush     = wr_ctrl & avs_byteenable[0] & avs_writedata[1];
    ovf_clr   = wr_status & avs_byteenable[0] & avs_writedata[6];
    empty     = (count == '0);
    full      = (count == CNT_W'(FIFO_DEPTH));
    pop_req   = rd_event & ~empty;
    push_req  = |press;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    do_pop    = pop_req & ~flush;
    do_push   = push_req & ~flush & (~full | pop_req);
    ovf_set   = push_req & ~flush & full & ~pop_req;
    eng_gnt   = eng_req & ~hps_bank;
    div_merged  = merge_bytes({8'h00, tick_div}, avs_writedata, avs_byteenable);
    bank_merged = merge_bytes(bank[avs_address[3:0]], avs_writedata, avs_byteenable);
  end

  // Read data selection for the registered HPS response.
  always_comb begin
    status_word = '0;
    status_word[CNT_W-1:0] = count;
    status_word[4] = empty;
    status_word[5] = full;
    status_word[6] = overflow;
    rd_mux = '0;
    if (avs_address[4]) begin
      rd_mux = bank[avs_address[3:0]];
    end else begin
      case (avs_address)
        REG_CTRL:     rd_mux = {31'h0, run};
        REG_STATUS:   rd_mux = status_word;
        REG_EVENT:    rd_mux = empty ? '0 : fifo_mem[rd_ptr];
        REG_TICK_DIV: rd_mux = {8'h00, tick_div};
        REG_TICK_CNT: rd_mux = tick_cnt;
        default:      rd_mux = '0;
      endcase
    end
  end

  // Registered HPS read response; holds until the next read.
  always_ff @(posedge clk) begin
    if (reset) avs_readdata <= '0;
    else if (avs_read) avs_readdata <= rd_mux;
  end

  // CTRL and TICK_DIV registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      run      <= 1'b0;
      tick_div <= '0;
    end else begin
      if (wr_ctrl && avs_byteenable[0]) run <= avs_writedata[0];
      if (wr_div) tick_div <= div_merged[23:0];
    end
  end

  // Tick prescaler and free-running tick counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc    <= '0;
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (wr_div) begin
        presc <= '0;
      end else if (run) begin
        if (presc == tick_div) begin
          presc    <= '0;
          tick     <= 1'b1;
          tick_cnt <= tick_cnt + 32'd1;
        end else begin
          presc <= presc + 24'd1;
        end
      end
    end
  end

  // Button synchronizer, reset to the released (high) raw level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  assign sync_lvl = ~sync2;

`ifdef GAME_BTN_DEBOUNCE_EN
  localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  logic [DEB_W-1:0] deb_cnt [BTN_W];
  logic [BTN_W-1:0] deb;

  // Accept a new level only after it has differed for DEB_CYCLES clocks in a row.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb <= '0;
      for (int unsigned i = 0; i < BTN_W; i++) deb_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < BTN_W; i++) begin
        if (sync_lvl[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
          deb[i]     <= sync_lvl[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign level = deb;
`else
  assign level = sync_lvl;
`endif

  assign press = level & ~level_q;

  // Edge-detect history of the button level.
  always_ff @(posedge clk) begin
    if (reset) level_q <= '0;
    else level_q <= level;
  end

  // Event FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (ovf_set) overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({do_push, do_pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Event FIFO storage: press mask with the current tick count as timestamp.
  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr] <= {tick_cnt[23:0], 8'(press)};
  end

  // Shared bank storage; the HPS and a granted engine write never coincide.
  always_ff @(posedge clk) begin
    if (wr_bank) bank[avs_address[3:0]] <= bank_merged;
    else if (eng_gnt && eng_we) bank[eng_addr] <= eng_wdata;
  end

  // Engine read response, one cycle after a granted read.
  always_ff @(posedge clk) begin
    if (reset) begin
      eng_rvalid <= 1'b0;
      eng_rdata  <= '0;
    end else begin
      eng_rvalid <= eng_gnt & ~eng_we;
      if (eng_gnt && !eng_we) eng_rdata <= bank[eng_addr];
    end
  end

endmodule

// File: tb/tb_game_mmio_ctrl.sv
// Testbench for game_mmio_ctrl. Expected read data is queued when each access
// is issued and popped when the response is sampled.
module tb_game_mmio_ctrl;

`ifdef GAME_BTN_DEBOUNCE_EN
  localparam int DEB = 4;
`else
  localparam int DEB = 0;
`endif
  localparam int HOLD = DEB + 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  avs_address = '0;
  logic [3:0]  avs_byteenable = '0;
  logic [31:0] avs_writedata = '0;
  logic        avs_write = 1'b0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_readdata;
  logic [4:0]  btn_in = '1;
  logic        eng_req = 1'b0;
  logic        eng_we = 1'b0;
  logic [3:0]  eng_addr = '0;
  logic [31:0] eng_wdata = '0;
  logic        eng_gnt;
  logic [31:0] eng_rdata;
  logic        eng_rvalid;
  logic        tick;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] evt_q[$];

  game_mmio_ctrl #(.BTN_W(5), .FIFO_DEPTH(8), .DEB_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .avs_address(avs_address), .avs_byteenable(avs_byteenable),
    .avs_writedata(avs_writedata), .avs_write(avs_write), .avs_read(avs_read),
    .avs_readdata(avs_readdata), .btn_in(btn_in),
    .eng_req(eng_req), .eng_we(eng_we), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
    .eng_gnt(eng_gnt), .eng_rdata(eng_rdata), .eng_rvalid(eng_rvalid), .tick(tick)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got still running, required finish");
    $fatal(1);
  end

  // Bus drivers: called just after a falling edge, return at the next falling edge.
  task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    avs_address = a; avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [31:0] got, exp;
    logic [4:0]  addrs [6] = '{5'h01, 5'h02, 5'h00, 5'h03, 5'h04, 5'h08};
    logic [31:0] exps  [6] = '{32'h10, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    vectors++;
    if ({avs_readdata, eng_rdata, eng_rvalid, tick} !== 66'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rd=%h erd=%h rv=%b tick=%b, required all 0",
               avs_readdata, eng_rdata, eng_rvalid, tick);
    end
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(exps[i]);
      bus_read(addrs[i], got);
      exp = exp_q.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL reset_read addr=%h: got %h, required %h", addrs[i], got, exp);
      end
    end
  endtask

  task automatic test_tick;
    logic [31:0] got, exp;
    logic        exp_tick;
    bus_write(5'h03, 32'd3, 4'hF);
    bus_write(5'h00, 32'd1, 4'h1);
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      exp_tick = (j % 4 == 0);
      vectors++;
      if (tick !== exp_tick) begin
        miscompares++;
        $display("FAIL tick_div3 cycle %0d: got %b, required %b", j, tick, exp_tick);
      end
      if (j == 19) begin
        avs_address = 5'h00; avs_writedata = 32'h0; avs_byteenable = 4'h1; avs_write = 1'b1;
      end
      if (j == 20) avs_write = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(32'd5);
      bus_read(5'h04, got);
      exp = exp_q.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL tick_cnt read %0d: got %h, required %h", k, got, exp);
      end
      idle(5);
    end
  endtask

  task automatic test_button;
    logic [31:0] got, exp;
    logic [4:0]  addrs [7] = '{5'h04, 5'h01, 5'h02, 5'h01, 5'h01, 5'h02, 5'h01};
    logic [31:0] exps  [7] = '{32'd7, 32'h01, 32'h704, 32'h10, 32'h01, 32'h711, 32'h10};
    bus_write(5'h03, 32'd0, 4'hF);
    bus_write(5'h00, 32'd1, 4'h1);
    @(negedge clk);
    vectors++;
    if (tick !== 1'b1) begin
      miscompares++;
      $display("FAIL tick_div0 first: got %b, required 1", tick);
    end
    avs_address = 5'h00; avs_writedata = 32'h0; avs_byteenable = 4'h1; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
    vectors++;
    if (tick !== 1'b1) begin
      miscompares++;
      $display("FAIL tick_div0 second: got %b, required 1", tick);
    end
    @(negedge clk);
    vectors++;
    if (tick !== 1'b0) begin
      miscompares++;
      $display("FAIL tick_stopped: got %b, required 0", tick);
    end
    for (int i = 0; i < 7; i++) begin
      if (i == 1) begin
        btn_in = ~5'b00100; idle(HOLD); btn_in = '1; idle(HOLD);
      end
      if (i == 4) begin
        btn_in = ~5'b10001; idle(HOLD); btn_in = '1; idle(HOLD);
      end
      exp_q.push_back(exps[i]);
      bus_read(addrs[i], got);
      exp = exp_q.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL button step %0d addr=%h: got %h, required %h", i, addrs[i], got, exp);
      end
    end
  endtask

  task automatic test_overflow;
    logic [31:0] got, exp;
    logic [4:0]  mask;
    for (int i = 0; i < 9; i++) begin
      mask = 5'b00001 << (i % 5);
      btn_in = ~mask; idle(HOLD); btn_in = '1; idle(HOLD);
      if (i < 8) evt_q.push_back({24'd7, 3'b000, mask});
    end
    exp_q.push_back(32'h68);
    bus_read(5'h01, got);
    exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL full_status: got %h, required %h", got, exp); end
    bus_write(5'h01, 32'h40, 4'h0);
    exp_q.push_back(32'h68);
    bus_read(5'h01, got);
    exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL ovf_clear_be0: got %h, required %h", got, exp); end
    exp_q.push_back(evt_q.pop_front());
    bus_read(5'h02, got);
    exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL oldest_event: got %h, required %h", got, exp); end
    exp_q.push_back(32'h47);
    bus_read(5'h01, got);
    exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL status_after_pop: got %h, required %h", got, exp); end
    bus_write(5'h00, 32'h2, 4'h1);
    evt_q.delete();
    exp_q.push_back(32'h50);
    bus_read(5'h01, got);
    exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL status_after_flush: got %h, required %h", got, exp); end
    exp_q.push_back(32'h0);
    bus_read(5'h02, got);
    exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL event_after_flush: got %h, required %h", got, exp); end
    exp_q.push_back(32'h0);
    bus_read(5'h00, got);
    exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL ctrl_flush_selfclear: got %h, required %h", got, exp); end
    bus_write(5'h01, 32'h40, 4'h1);
    bus_write(5'h08, 32'hDEADBEEF, 4'hF);
    exp_q.push_back(32'h10);
    bus_read(5'h01, got);
    exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL ovf_clear_be1: got %h, required %h", got, exp); end
    exp_q.push_back(32'h0);
    bus_read(5'h08, got);
    exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL unmapped_read: got %h, required %h", got, exp); end
  endtask

  task automatic test_engine;
    logic [31:0] got, exp;
    eng_req = 1'b1; eng_we = 1'b0; eng_addr = 4'h3;
    for (int k = 0; k < 3; k++) begin
      avs_address = 5'h13; avs_writedata = 32'hA5A50000 + k; avs_byteenable = 4'hF; avs_write = 1'b1;
      #1;
      vectors++;
      if (eng_gnt !== 1'b0) begin miscompares++; $display("FAIL gnt_blocked %0d: got %b, required 0", k, eng_gnt); end
      @(negedge clk);
    end
    avs_write = 1'b0;
    #1;
    vectors++;
    if (eng_gnt !== 1'b1) begin miscompares++; $display("FAIL gnt_released: got %b, required 1", eng_gnt); end
    exp_q.push_back(32'hA5A50002);
    @(negedge clk);
    eng_req = 1'b0;
    exp = exp_q.pop_front(); vectors++;
    if (eng_rvalid !== 1'b1 || eng_rdata !== exp) begin
      miscompares++;
      $display("FAIL eng_read_hps_value: got rv=%b data=%h, required rv=1 data=%h", eng_rvalid, eng_rdata, exp);
    end
    @(negedge clk);
    vectors++;
    if (eng_rvalid !== 1'b0) begin miscompares++; $display("FAIL eng_rvalid_drop: got %b, required 0", eng_rvalid); end
    eng_req = 1'b1; eng_we = 1'b0; eng_addr = 4'h0;
    avs_address = 5'h14; avs_read = 1'b1;
    #1;
    vectors++;
    if (eng_gnt !== 1'b0) begin miscompares++; $display("FAIL gnt_hps_read: got %b, required 0", eng_gnt); end
    @(negedge clk);
    avs_read = 1'b0;
    eng_we = 1'b1; eng_addr = 4'h5; eng_wdata = 32'h12345678;
    vectors++;
    if (eng_rvalid !== 1'b0) begin miscompares++; $display("FAIL rvalid_denied: got %b, required 0", eng_rvalid); end
    #1;
    vectors++;
    if (eng_gnt !== 1'b1) begin miscompares++; $display("FAIL gnt_eng_write: got %b, required 1", eng_gnt); end
    @(negedge clk);
    eng_we = 1'b0;
    exp_q.push_back(32'h12345678);
    @(negedge clk);
    eng_req = 1'b0;
    exp = exp_q.pop_front(); vectors++;
    if (eng_rvalid !== 1'b1 || eng_rdata !== exp) begin
      miscompares++;
      $display("FAIL eng_write_readback: got rv=%b data=%h, required rv=1 data=%h", eng_rvalid, eng_rdata, exp);
    end
    exp_q.push_back(32'h12345678);
    bus_read(5'h15, got);
    exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL hps_read_eng_word: got %h, required %h", got, exp); end
    bus_write(5'h15, 32'hFFFFFFFF, 4'b0011);
    exp_q.push_back(32'h1234FFFF);
    bus_read(5'h15, got);
    exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL bank_byteenable: got %h, required %h", got, exp); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] got, exp;
    bus_write(5'h03, 32'h00ABCDEF, 4'hF);
    exp_q.push_back(32'h00ABCDEF);
    bus_read(5'h03, got);
    exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL tick_div_readback: got %h, required %h", got, exp); end
    avs_address = 5'h03; avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if (avs_readdata !== 32'h0) begin miscompares++; $display("FAIL reset_mid_access: got %h, required 0", avs_readdata); end
    exp_q.push_back(32'h0);
    bus_read(5'h03, got);
    exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL tick_div_after_reset: got %h, required %h", got, exp); end
  endtask

`ifdef GAME_BTN_DEBOUNCE_EN
  task automatic test_debounce;
    logic [31:0] got, exp;
    btn_in = ~5'b00001; idle(3); btn_in = '1; idle(12);
    exp_q.push_back(32'h10);
    bus_read(5'h01, got);
    exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL debounce_glitch: got %h, required %h", got, exp); end
    btn_in = ~5'b00001; idle(6); btn_in = '1; idle(12);
    exp_q.push_back(32'h01);
    bus_read(5'h01, got);
    exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL debounce_press_count: got %h, required %h", got, exp); end
    exp_q.push_back(32'h01);
    bus_read(5'h02, got);
    exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL debounce_event: got %h, required %h", got, exp); end
  endtask
`endif

  initial begin
    test_reset();
    test_tick();
    test_button();
    test_overflow();
    test_engine();
    test_reset_mid();
`ifdef GAME_BTN_DEBOUNCE_EN
    test_debounce();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
